btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have the parameter NBTN, default 3, giving the number of independent button channels (index 0 start, 1 pause, 2 reset); legal range 1..8.
REQ-002 The block SHALL have the parameter DB_CYCLES, default 200000, giving the stable-input cycles required to accept a level change; legal range >=1.
REQ-003 The block SHALL have the parameter LONG_CYCLES, default 50000000, giving the held cycles for a long press; legal range >DB_CYCLES.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port btn_raw, input, NBTN bits: asynchronous, bouncing raw button levels, 1 = pressed.
REQ-007 The block SHALL have the port btn_level, output, NBTN bits: debounced level per channel.
REQ-008 The block SHALL have the port btn_press, output, NBTN bits: one-cycle pulse on an accepted press.
REQ-009 The block SHALL have the port btn_release, output, NBTN bits: one-cycle pulse on an accepted release.
REQ-010 The block SHALL have the port btn_long, output, NBTN bits: one-cycle pulse on a long press (see Configuration).

Function
REQ-011 Each channel SHALL pass btn_raw through a two-flop synchronizer; only the second flop output s feeds the FSM.
REQ-012 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a debounce counter of width clog2(DB_CYCLES)+1.
REQ-013 In IDLE, the FSM SHALL move to PRESS_WAIT with cnt=0 when s=1, and otherwise stay.
REQ-014 In PRESS_WAIT, the FSM SHALL return to IDLE when s=0; when s=1 and cnt==DB_CYCLES-1 it SHALL enter HELD, set btn_level=1 and pulse btn_press; otherwise it SHALL increment cnt.
REQ-015 In HELD, the FSM SHALL move to RELEASE_WAIT with cnt=0 when s=0.
REQ-016 In RELEASE_WAIT, the FSM SHALL return to HELD when s=1 with no pulse; when s=0 and cnt==DB_CYCLES-1 it SHALL enter IDLE, set btn_level=0 and pulse btn_release; otherwise it SHALL increment cnt.
REQ-017 Press latency SHALL be exact: for btn_raw held stable high, btn_press SHALL be high for exactly the one cycle following rising edge DB_CYCLES+3, counting the first edge that samples raw high as edge 1; release latency SHALL be the same.
REQ-018 A bounce shorter than DB_CYCLES consecutive stable samples SHALL produce no pulse and no btn_level change.
REQ-019 btn_press, btn_release and btn_long SHALL be registered, high for exactly one cycle per event, and never high in consecutive cycles on the same channel.
REQ-020 Channels SHALL be fully independent; pulses on several channels in the same cycle are legal and SHALL all be reported.
REQ-021 btn_level SHALL change only in the same cycle as the matching btn_press or btn_release pulse.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL clear the synchronizers, cnt and the long counters to 0, set every FSM to IDLE, and drive all outputs to 0.
REQ-023 Reset mid-operation SHALL abort any pending event without a pulse; a button still held after rst deasserts SHALL be re-debounced and produce btn_press per REQ-017, counted from the first post-reset edge.

Configuration
REQ-024 With macro BTN_DEBOUNCE_LONG_PRESS_EN defined, each channel SHALL have a saturating long counter cleared on the PRESS_WAIT->HELD transition, incremented each cycle in HELD and in RELEASE_WAIT, and btn_long SHALL pulse once when it reaches LONG_CYCLES-1 (counting from the btn_press cycle), with at most one pulse per press.
REQ-025 Without BTN_DEBOUNCE_LONG_PRESS_EN, the block SHALL tie btn_long to 0 and synthesise no long counter; all other behaviour SHALL be identical.

Verification (DB_CYCLES=4, LONG_CYCLES=16, NBTN=3)
REQ-026 Clean press: btn_raw[0] goes 0->1 and is held -> btn_press[0] is high only after edge 7 and btn_level[0]=1 from then on.
REQ-027 Bounce: btn_raw[1] toggles 1,0,1,0 once per cycle then settles at 0 -> no pulses and btn_level[1] stays 0; a later 1-cycle low glitch while held -> no btn_release.
REQ-028 Release: after REQ-026, btn_raw[0] goes 1->0 and is held -> btn_release[0] is high for exactly one cycle, 7 edges later, and btn_level[0]=0.
REQ-029 Simultaneous: btn_raw = 3'b111 in one cycle -> btn_press = 3'b111 in the same single cycle.
REQ-030 Long press with macro: btn_raw[2] held for 40 cycles -> exactly one btn_long[2] pulse, 15 cycles after btn_press[2]; without the macro, btn_long stays 0.
REQ-031 Reset mid-press: rst is pulsed at edge 5 of REQ-026 with the button still held -> no pulse near edge 7, and btn_press[0] fires 7 edges after rst deasserts.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-channel button debouncer: 2-flop sync, 4-state FSM, registered press/release/long pulses.
// Optional long-press detection is enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce #(
   parameter int NBTN        = 3,
   parameter int DB_CYCLES   = 200000,
   parameter int LONG_CYCLES = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic [NBTN-1:0] btn_long
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam int            CW       = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   for (genvar ch = 0; ch < NBTN; ch++) begin : g_ch
      logic          sync1;
      logic          s;
      state_t        state;
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          press_q;
      logic          rel_q;
      logic          accept_press;

      // The PRESS_WAIT->HELD condition is shared with the long-press counter clear.
      assign accept_press = (state == PRESS_WAIT) && s && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1   <= 1'b0;
            s       <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            sync1   <= btn_raw[ch];
            s       <= sync1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state)
               IDLE: begin
                  if (s) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!s) begin
                     state <= IDLE;
                  end else if (cnt == CNT_LAST) begin
                     state   <= HELD;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (!s) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (s) begin
                     state <= HELD;
                  end else if (cnt == CNT_LAST) begin
                     state   <= IDLE;
                     level_q <= 1'b0;
                     rel_q   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign btn_level[ch]   = level_q;
      assign btn_press[ch]   = press_q;
      assign btn_release[ch] = rel_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      localparam int            LW        = $clog2(LONG_CYCLES) + 1;
      localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
      localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

      logic [LW-1:0] long_cnt;
      logic          long_q;

      // Saturating at LONG_LAST guarantees a single pulse per press.
      always_ff @(posedge clk) begin
         if (rst) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (accept_press) begin
               long_cnt <= '0;
            end else if ((state == HELD || state == RELEASE_WAIT) && long_cnt != LONG_LAST) begin
               long_cnt <= long_cnt + 1'b1;
               long_q   <= (long_cnt == LONG_PRE);
            end
         end
      end

      assign btn_long[ch] = long_q;
`else
      assign btn_long[ch] = 1'b0;
`endif
   end

endmodule
